simple_wb_branch: RTL and testbench
===================================

# simple_wb_branch

Writeback and branch-resolution stage that sits after the immediate-class execute unit of the 16-bit SIMPLE core. It takes that unit's result word, SVZC flags and write/branch strobes, and commits each instruction's architectural effects one cycle later:
- register-file write;
- flag-register update;
- PC redirect.

On a taken branch it squashes younger instructions for a fixed number of cycles.

## Interface
Parameters:
- FLUSH_CYCLES, 2, number of cycles `flush` stays high after a taken branch (1..7).

Ports (one clock `clk`; `reset` is synchronous, active-high):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- stall  in  1  hold; no instruction accepted this cycle
- isValid  in  1  execute-stage instruction valid
- out  in  16  execute result / branch target (PC+1+d)
- S, V, Z, C  in  1 each  flags computed by the execute unit
- SVZCWriteFlag  in  1  update the flag register
- IRdWriteFlag  in  1  write `out` to the register file
- is_10100  in  1  unconditional branch B
- is_10111  in  1  conditional branch; condition code on `rd`
- rd  in  3  destination register, or condition code for is_10111
- rf_we  out  1  register-file write strobe
- rf_waddr  out  3  write address
- rf_wdata  out  16  write data
- flag_s, flag_v, flag_z, flag_c  out  1 each  architectural flag register
- pc_load  out  1  one-cycle PC redirect strobe
- pc_next  out  16  redirect target
- flush  out  1  squash signal to fetch/decode/execute
- retire_count  out  16  committed-instruction counter

## Operation
Accept rule:
- An instruction is accepted when `isValid & ~stall & state==IDLE`.
- Strobes presented in FLUSH, or while stall is high, are ignored.

Commit on acceptance (all effects registered at the next edge):
- IRdWriteFlag: rf_we=1, rf_waddr=rd, rf_wdata=out.
- SVZCWriteFlag: flag_* ← S,V,Z,C.
- is_10100: branch taken.
- is_10111: taken when the condition below holds, evaluated on the current flag_* register (flags of the previous committed instruction).
- Taken branch: pc_load=1, pc_next=out, state→FLUSH.
- retire_count increments by 1, wrapping FFFF→0000.

Condition codes for is_10111 (rd):
- 000 BE: Z
- 001 BLT: S^V
- 010 BLE: Z|(S^V)
- 011 BNE: ~Z
- 100..111: never taken; the instruction still retires.

Strobes that are not asserted for an instruction leave their targets unchanged.

FSM:
- IDLE→FLUSH on a taken branch; counter loaded with FLUSH_CYCLES.
- In FLUSH the counter decrements every cycle, independent of stall.
- FLUSH→IDLE at the edge where the counter reaches 1.

## Timing
- Latency: commit outputs are valid one cycle after acceptance.
- rf_we and pc_load are single-cycle pulses; rf_waddr, rf_wdata and pc_next hold their last value.
- flush is high for exactly FLUSH_CYCLES cycles, starting in the same cycle as pc_load.
- The first new instruction can be accepted in the cycle after flush falls.
- Back-to-back acceptance in IDLE with no bubbles.
- stall high: no strobe pulses, flags and counter hold. A stall arriving mid-FLUSH does not extend flush.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, flag_*=0, pc_load=0, pc_next=0, flush=0, retire_count=0, state=IDLE.
- Reset mid-FLUSH aborts the flush in the next cycle.
- Simultaneous SVZCWriteFlag with a branch strobe does not occur. If it does, the flag write wins and the branch uses the old flags.

## Configuration
`SIMPLE_WB_BYPASS_EN`
- Defined: adds outputs byp_valid (1), byp_addr (3) and byp_data (16), driven combinationally as IRdWriteFlag-acceptance, rd and out in the acceptance cycle, for operand forwarding to decode.
- Undefined: these ports do not exist, and the core inserts a one-cycle read-after-write bubble instead.

## Structure
Shared package `simple_pkg`:
- Condition-code localparams: CC_BE, CC_BLT, CC_BLE, CC_BNE.
- Flags struct {s, v, z, c}.
- FSM state enum: IDLE, FLUSH.

Sub-module `simple_cond_eval`: combinational, 3-bit code + flags in, `taken` out. The decode stage reuses it.

## Test plan
- Reset, then isValid with IRdWriteFlag, rd=3, out=1234 → next cycle rf_we=1, rf_waddr=3, rf_wdata=1234; retire_count=1.
- SVZCWriteFlag with Z=1, then is_10111 with rd=000, out=0040 → pc_load=1, pc_next=0040, flush high for 2 cycles; an isValid presented during flush is not committed.
- Flags S=1, V=0, then is_10111 with rd=011 (BNE, Z=0) → taken; with rd=101 → not taken, but retire_count still increments.
- stall=1 with isValid and IRdWriteFlag → no rf_we and no count change; 4 back-to-back ADDI after stall falls → 4 consecutive rf_we pulses.
- Preload retire_count to FFFF, retire 1 instruction → count becomes 0000. Reset asserted in the first flush cycle → flush=0 next cycle and all outputs at reset values.
- With SIMPLE_WB_BYPASS_EN: IRdWriteFlag, rd=5, out=00AA → byp_valid=1, byp_addr=5, byp_data=00AA in the same cycle as acceptance.

Source files
------------

// File: rtl/simple_pkg.sv
// Shared definitions for the SIMPLE core back end.
// Contains the condition codes, the flag bundle and the writeback FSM states.
package simple_pkg;

    localparam logic [2:0] CC_BE  = 3'b000;
    localparam logic [2:0] CC_BLT = 3'b001;
    localparam logic [2:0] CC_BLE = 3'b010;
    localparam logic [2:0] CC_BNE = 3'b011;

    typedef struct packed {
        logic s;
        logic v;
        logic z;
        logic c;
    } flags_t;

    typedef enum logic {
        IDLE,
        FLUSH
    } wbState_t;

endpackage

// File: rtl/simple_cond_eval.sv
// Branch condition evaluator: decides from a 3-bit condition code and a flag set whether a branch is taken.
// The decode stage also uses this block.
import simple_pkg::*;

module simple_cond_eval (
    input  logic [2:0] cc,
    input  flags_t     flags,
    output logic       taken
);

    // Codes 100..111 are reserved and never branch.
    always_comb begin
        taken = 1'b0;
        case (cc)
            CC_BE:   taken = flags.z;
            CC_BLT:  taken = flags.s ^ flags.v;
            CC_BLE:  taken = flags.z | (flags.s ^ flags.v);
            CC_BNE:  taken = ~flags.z;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/simple_wb_branch.sv
// Writeback and branch-resolution stage for the SIMPLE core. It commits register, flag and PC effects one cycle after acceptance.
// Optional macro SIMPLE_WB_BYPASS_EN adds combinational forwarding outputs byp_valid/byp_addr/byp_data.
import simple_pkg::*;

module simple_wb_branch #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        isValid,
    input  logic [15:0] out,
    input  logic        S,
    input  logic        V,
    input  logic        Z,
    input  logic        C,
    input  logic        SVZCWriteFlag,
    input  logic        IRdWriteFlag,
    input  logic        is_10100,
    input  logic        is_10111,
    input  logic [2:0]  rd,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic        flag_s,
    output logic        flag_v,
    output logic        flag_z,
    output logic        flag_c,
    output logic        pc_load,
    output logic [15:0] pc_next,
    output logic        flush,
`ifdef SIMPLE_WB_BYPASS_EN
    output logic        byp_valid,
    output logic [2:0]  byp_addr,
    output logic [15:0] byp_data,
`endif
    output logic [15:0] retire_count
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    wbState_t    state_q, state_d;
    logic [2:0]  flushCnt_q, flushCnt_d;
    flags_t      flags_q, flags_d;
    logic        rfWe_q, rfWe_d;
    logic [2:0]  rfWaddr_q, rfWaddr_d;
    logic [15:0] rfWdata_q, rfWdata_d;
    logic        pcLoad_q, pcLoad_d;
    logic [15:0] pcNext_q, pcNext_d;
    logic [15:0] retireCnt_q, retireCnt_d;

    logic accept;
    logic rdWrite;
    logic condTaken;
    logic branchTaken;

    // Conditional branches look at the committed flags, i.e. those of the previous instruction.
    simple_cond_eval u_condEval (
        .cc    (rd),
        .flags (flags_q),
        .taken (condTaken)
    );

    assign accept      = isValid & ~stall & (state_q == IDLE);
    assign rdWrite     = accept & IRdWriteFlag;
    assign branchTaken = accept & (is_10100 | (is_10111 & condTaken));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            flushCnt_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    // The flush countdown runs regardless of stall so a stall cannot stretch flush.
    always_comb begin
        state_d    = state_q;
        flushCnt_d = flushCnt_q;
        case (state_q)
            IDLE: begin
                if (branchTaken) begin
                    state_d    = FLUSH;
                    flushCnt_d = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                flushCnt_d = flushCnt_q - 3'd1;
                if (flushCnt_q <= 3'd1) begin
                    state_d    = IDLE;
                    flushCnt_d = 3'd0;
                end
            end
            default: begin
                state_d    = IDLE;
                flushCnt_d = 3'd0;
            end
        endcase
    end

    always_comb begin
        flush = (state_q == FLUSH);
    end

    always_comb begin
        rfWe_d      = rdWrite;
        rfWaddr_d   = rdWrite ? rd : rfWaddr_q;
        rfWdata_d   = rdWrite ? out : rfWdata_q;
        flags_d     = (accept & SVZCWriteFlag) ? flags_t'({S, V, Z, C}) : flags_q;
        pcLoad_d    = branchTaken;
        pcNext_d    = branchTaken ? out : pcNext_q;
        retireCnt_d = accept ? retireCnt_q + 16'd1 : retireCnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rfWe_q      <= 1'b0;
            rfWaddr_q   <= 3'd0;
            rfWdata_q   <= 16'd0;
            flags_q     <= '0;
            pcLoad_q    <= 1'b0;
            pcNext_q    <= 16'd0;
            retireCnt_q <= 16'd0;
        end else begin
            rfWe_q      <= rfWe_d;
            rfWaddr_q   <= rfWaddr_d;
            rfWdata_q   <= rfWdata_d;
            flags_q     <= flags_d;
            pcLoad_q    <= pcLoad_d;
            pcNext_q    <= pcNext_d;
            retireCnt_q <= retireCnt_d;
        end
    end

    assign rf_we        = rfWe_q;
    assign rf_waddr     = rfWaddr_q;
    assign rf_wdata     = rfWdata_q;
    assign flag_s       = flags_q.s;
    assign flag_v       = flags_q.v;
    assign flag_z       = flags_q.z;
    assign flag_c       = flags_q.c;
    assign pc_load      = pcLoad_q;
    assign pc_next      = pcNext_q;
    assign retire_count = retireCnt_q;

`ifdef SIMPLE_WB_BYPASS_EN
    assign byp_valid = rdWrite;
    assign byp_addr  = rd;
    assign byp_data  = out;
`endif

endmodule

// File: tb/tb_simple_wb_branch.sv
// Directed self-checking bench for simple_wb_branch with hand-computed expectations.
// Checks the forwarding outputs when SIMPLE_WB_BYPASS_EN is defined.
module tb_simple_wb_branch;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        isValid;
    logic [15:0] out;
    logic        S, V, Z, C;
    logic        SVZCWriteFlag;
    logic        IRdWriteFlag;
    logic        is_10100;
    logic        is_10111;
    logic [2:0]  rd;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        flag_s, flag_v, flag_z, flag_c;
    logic        pc_load;
    logic [15:0] pc_next;
    logic        flush;
    logic [15:0] retire_count;
`ifdef SIMPLE_WB_BYPASS_EN
    logic        byp_valid;
    logic [2:0]  byp_addr;
    logic [15:0] byp_data;
`endif

    int checkCount;
    int errorCount;

    simple_wb_branch #(.FLUSH_CYCLES(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .isValid       (isValid),
        .out           (out),
        .S             (S),
        .V             (V),
        .Z             (Z),
        .C             (C),
        .SVZCWriteFlag (SVZCWriteFlag),
        .IRdWriteFlag  (IRdWriteFlag),
        .is_10100      (is_10100),
        .is_10111      (is_10111),
        .rd            (rd),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .flag_s        (flag_s),
        .flag_v        (flag_v),
        .flag_z        (flag_z),
        .flag_c        (flag_c),
        .pc_load       (pc_load),
        .pc_next       (pc_next),
        .flush         (flush),
`ifdef SIMPLE_WB_BYPASS_EN
        .byp_valid     (byp_valid),
        .byp_addr      (byp_addr),
        .byp_data      (byp_data),
`endif
        .retire_count  (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Inputs change 1ns after a rising edge, so registered outputs are settled when checked.
    task automatic applyStimulus(input logic valid, input logic stl, input logic [15:0] data,
                                 input logic [3:0] svzc, input logic svzcW, input logic irdW,
                                 input logic br, input logic bc, input logic [2:0] rdIn);
        isValid       = valid;
        stall         = stl;
        out           = data;
        {S, V, Z, C}  = svzc;
        SVZCWriteFlag = svzcW;
        IRdWriteFlag  = irdW;
        is_10100      = br;
        is_10111      = bc;
        rd            = rdIn;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;

        checkOutput("rst_rf_we", {31'd0, rf_we}, 32'd0);
        checkOutput("rst_waddr", {29'd0, rf_waddr}, 32'd0);
        checkOutput("rst_wdata", {16'd0, rf_wdata}, 32'd0);
        checkOutput("rst_flags", {28'd0, flag_s, flag_v, flag_z, flag_c}, 32'd0);
        checkOutput("rst_pc", {15'd0, pc_load, pc_next}, 32'd0);
        checkOutput("rst_flush", {31'd0, flush}, 32'd0);
        checkOutput("rst_retire", {16'd0, retire_count}, 32'd0);

        applyStimulus(1'b1, 1'b0, 16'h1234, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3);
        tick();
        checkOutput("wr_we", {31'd0, rf_we}, 32'd1);
        checkOutput("wr_waddr", {29'd0, rf_waddr}, 32'd3);
        checkOutput("wr_wdata", {16'd0, rf_wdata}, 32'h1234);
        checkOutput("wr_retire", {16'd0, retire_count}, 32'd1);
        idle();
        tick();
        checkOutput("wr_we_pulse", {31'd0, rf_we}, 32'd0);
        checkOutput("wr_wdata_hold", {16'd0, rf_wdata}, 32'h1234);

        // Z=1 then BE taken
        applyStimulus(1'b1, 1'b0, 16'h0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        checkOutput("flag_z_set", {28'd0, flag_s, flag_v, flag_z, flag_c}, 32'b0010);
        checkOutput("flag_retire", {16'd0, retire_count}, 32'd2);
        applyStimulus(1'b1, 1'b0, 16'h0040, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
        tick();
        checkOutput("be_pc_load", {31'd0, pc_load}, 32'd1);
        checkOutput("be_pc_next", {16'd0, pc_next}, 32'h0040);
        checkOutput("be_flush1", {31'd0, flush}, 32'd1);
        checkOutput("be_retire", {16'd0, retire_count}, 32'd3);
        applyStimulus(1'b1, 1'b0, 16'hBEEF, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd7);
        tick();
        checkOutput("be_pc_pulse", {31'd0, pc_load}, 32'd0);
        checkOutput("be_flush2", {31'd0, flush}, 32'd1);
        checkOutput("fl_no_we1", {31'd0, rf_we}, 32'd0);
        tick();
        checkOutput("be_flush_end", {31'd0, flush}, 32'd0);
        checkOutput("fl_no_we2", {31'd0, rf_we}, 32'd0);
        checkOutput("fl_retire", {16'd0, retire_count}, 32'd3);
        tick();
        checkOutput("after_fl_we", {31'd0, rf_we}, 32'd1);
        checkOutput("after_fl_wdata", {16'd0, rf_wdata}, 32'hBEEF);
        checkOutput("after_fl_retire", {16'd0, retire_count}, 32'd4);

        // S=1 V=0 Z=0 C=1
        applyStimulus(1'b1, 1'b0, 16'h0, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        checkOutput("flags_svzc", {28'd0, flag_s, flag_v, flag_z, flag_c}, 32'b1001);
        applyStimulus(1'b1, 1'b0, 16'h0100, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011);
        tick();
        checkOutput("bne_taken", {31'd0, pc_load}, 32'd1);
        checkOutput("bne_pc", {16'd0, pc_next}, 32'h0100);
        checkOutput("bne_flags_hold", {28'd0, flag_s, flag_v, flag_z, flag_c}, 32'b1001);
        idle();
        tick();
        tick();
        applyStimulus(1'b1, 1'b0, 16'h0180, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001);
        tick();
        checkOutput("blt_taken", {31'd0, pc_load}, 32'd1);
        checkOutput("blt_pc", {16'd0, pc_next}, 32'h0180);
        checkOutput("blt_retire", {16'd0, retire_count}, 32'd7);
        idle();
        tick();
        tick();
        applyStimulus(1'b1, 1'b0, 16'h0200, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b101);
        tick();
        checkOutput("cc101_not_taken", {31'd0, pc_load}, 32'd0);
        checkOutput("cc101_pc_hold", {16'd0, pc_next}, 32'h0180);
        checkOutput("cc101_no_flush", {31'd0, flush}, 32'd0);
        checkOutput("cc101_retire", {16'd0, retire_count}, 32'd8);
        applyStimulus(1'b1, 1'b0, 16'h0220, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
        tick();
        checkOutput("be_not_taken", {31'd0, pc_load}, 32'd0);
        applyStimulus(1'b1, 1'b0, 16'h0300, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        tick();
        checkOutput("b_taken", {31'd0, pc_load}, 32'd1);
        checkOutput("b_pc", {16'd0, pc_next}, 32'h0300);
        checkOutput("b_retire", {16'd0, retire_count}, 32'd10);
        applyStimulus(1'b1, 1'b1, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        checkOutput("stall_fl_2", {31'd0, flush}, 32'd1);
        tick();
        checkOutput("stall_fl_end", {31'd0, flush}, 32'd0);

        applyStimulus(1'b1, 1'b1, 16'h1111, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2);
        tick();
        checkOutput("stall_no_we", {31'd0, rf_we}, 32'd0);
        checkOutput("stall_retire", {16'd0, retire_count}, 32'd10);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 1'b0, 16'(i * 16'h11), 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'(i));
            tick();
            checkOutput("b2b_we", {31'd0, rf_we}, 32'd1);
            checkOutput("b2b_waddr", {29'd0, rf_waddr}, 32'(i));
            checkOutput("b2b_retire", {16'd0, retire_count}, 32'(10 + i));
        end
        idle();
        tick();
        checkOutput("b2b_we_end", {31'd0, rf_we}, 32'd0);

`ifdef SIMPLE_WB_BYPASS_EN
        applyStimulus(1'b1, 1'b0, 16'h00AA, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5);
        #1;
        checkOutput("byp_valid", {31'd0, byp_valid}, 32'd1);
        checkOutput("byp_addr", {29'd0, byp_addr}, 32'd5);
        checkOutput("byp_data", {16'd0, byp_data}, 32'h00AA);
        tick();
        idle();
        #1;
        checkOutput("byp_idle", {31'd0, byp_valid}, 32'd0);
        applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 65520; i++) tick();
`else
        applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 65521; i++) tick();
`endif
        checkOutput("retire_ffff", {16'd0, retire_count}, 32'hFFFF);
        tick();
        checkOutput("retire_wrap", {16'd0, retire_count}, 32'h0000);

        applyStimulus(1'b1, 1'b0, 16'h0500, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 3'd6);
        tick();
        checkOutput("pre_rst_flush", {31'd0, flush}, 32'd1);
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        checkOutput("rstfl_flush", {31'd0, flush}, 32'd0);
        checkOutput("rstfl_pc", {15'd0, pc_load, pc_next}, 32'd0);
        checkOutput("rstfl_rf", {12'd0, rf_we, rf_waddr, rf_wdata}, 32'd0);
        checkOutput("rstfl_retire", {16'd0, retire_count}, 32'd0);
        checkOutput("rstfl_flags", {28'd0, flag_s, flag_v, flag_z, flag_c}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
